frame_capture_pingpong_buffer: RTL and testbench

// - Successor to the free-running serial-in/RAM-out capture buffer: framed, double-banked (ping-pong) capture of a sample stream.
// - Writer fills one bank while the consumer reads the other by random address; the bank is handed over with a length and overflow flag.
// - Sits between the demod/bit-slicer output and the packet/CRC parser, so capture continues while the previous frame is parsed.

---
 rtl/frame_capture_pingpong_buffer_pkg.sv | 24 ++
 rtl/frame_capture_pingpong_buffer_dpram.sv | 37 +++
 rtl/frame_capture_pingpong_buffer.sv | 239 +++++++++++++++++++++++
 tb/tb_frame_capture_pingpong_buffer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_capture_pingpong_buffer_pkg.sv
// Shared configuration for the ping-pong frame capture buffer:
// bank count, writer FSM encoding and drop-counter sizing.
package frame_capture_pingpong_buffer_pkg;

  localparam int NUM_BANKS = 2;
  localparam int DROP_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DISCARD = 2'd2
  } cap_state_e;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    logic [DROP_W-1:0] r;
    if (v == {DROP_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(DROP_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_capture_pingpong_buffer_dpram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Array contents are not reset; only the read register is.
module frame_capture_pingpong_buffer_dpram #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic [ADDRESS_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0]    read_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];
  logic [DATA_WIDTH-1:0] read_data_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem[write_addr] <= write_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      read_data_q <= mem[read_addr];
    end
  end

  assign read_data = read_data_q;

endmodule

// File: rtl/frame_capture_pingpong_buffer.sv
// Framed ping-pong capture: the writer fills one bank while the reader
// inspects the other; banks are handed over in capture order with length/overflow.
module frame_capture_pingpong_buffer
  import frame_capture_pingpong_buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 6,
  parameter int WRAP_MODE     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     frame_start,
  input  logic                     frame_end,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_in_valid,
  output logic                     frame_ready,
  output logic [ADDRESS_WIDTH:0]   frame_len,
  output logic                     frame_ovf,
  input  logic                     frame_release,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]    data,
  output logic [DROP_W-1:0]        drop_count
);

  localparam logic [ADDRESS_WIDTH:0] LEN_FULL = (ADDRESS_WIDTH+1)'(2**ADDRESS_WIDTH);

  cap_state_e                           state_q, state_d;
  logic                                 wr_bank_q, wr_bank_d;
  logic                                 rd_bank_q, rd_bank_d;
  logic [NUM_BANKS-1:0]                 committed_q, committed_d;
  logic [ADDRESS_WIDTH-1:0]             wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH:0]               len_q, len_d;
  logic                                 ovf_q, ovf_d;
  logic [NUM_BANKS-1:0][ADDRESS_WIDTH:0] bank_len_q, bank_len_d;
  logic [NUM_BANKS-1:0]                 bank_ovf_q, bank_ovf_d;
  logic [DROP_W-1:0]                    drop_q, drop_d;
  logic                                 frame_ready_q, frame_ready_d;
  logic [ADDRESS_WIDTH:0]               frame_len_q, frame_len_d;
  logic                                 frame_ovf_q, frame_ovf_d;

  logic                                 we_s;
  logic [ADDRESS_WIDTH:0]               waddr_s;
  logic                                 release_s;
  logic                                 open_req_s;
  logic                                 open_bank_s;
  logic [ADDRESS_WIDTH-1:0]             cap_ptr_s;
  logic [ADDRESS_WIDTH:0]               cap_len_s;
  logic                                 cap_ovf_s;

  // Writer FSM, bank bookkeeping and next presented-frame status.
  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    committed_d = committed_q;
    wr_ptr_d    = wr_ptr_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    bank_len_d  = bank_len_q;
    bank_ovf_d  = bank_ovf_q;
    drop_d      = drop_q;
    we_s        = 1'b0;
    waddr_s     = {wr_bank_q, wr_ptr_q};
    open_req_s  = 1'b0;
    open_bank_s = wr_bank_q;
    cap_ptr_s   = wr_ptr_q;
    cap_len_s   = len_q;
    cap_ovf_s   = ovf_q;

    // A release is only meaningful while the reader actually holds a bank.
    release_s = frame_release && committed_q[rd_bank_q];
    if (release_s) begin
      committed_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          open_req_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (frame_start) begin
          open_req_s = 1'b1;
        end else if (frame_end) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      ST_CAPTURE: begin
        // Restart alone aborts the frame; with frame_end it closes it instead.
        if (frame_start && !frame_end) begin
          cap_ptr_s = {ADDRESS_WIDTH{1'b0}};
          cap_len_s = {(ADDRESS_WIDTH+1){1'b0}};
          cap_ovf_s = 1'b0;
        end else begin
          cap_ovf_s = ovf_q;
        end
        if (data_in_valid) begin
          if (cap_len_s == LEN_FULL) begin
            cap_ovf_s = 1'b1;
            if (WRAP_MODE != 0) begin
              we_s      = 1'b1;
              waddr_s   = {wr_bank_q, cap_ptr_s};
              cap_ptr_s = cap_ptr_s + ADDRESS_WIDTH'(1);
            end else begin
              we_s = 1'b0;
            end
          end else begin
            we_s      = 1'b1;
            waddr_s   = {wr_bank_q, cap_ptr_s};
            cap_ptr_s = cap_ptr_s + ADDRESS_WIDTH'(1);
            cap_len_s = cap_len_s + (ADDRESS_WIDTH+1)'(1);
          end
        end else begin
          we_s = 1'b0;
        end
        wr_ptr_d = cap_ptr_s;
        len_d    = cap_len_s;
        ovf_d    = cap_ovf_s;
        if (frame_end) begin
          bank_len_d[wr_bank_q]  = cap_len_s;
          bank_ovf_d[wr_bank_q]  = cap_ovf_s;
          committed_d[wr_bank_q] = 1'b1;
          wr_bank_d              = ~wr_bank_q;
          state_d                = ST_IDLE;
          if (frame_start) begin
            open_req_s  = 1'b1;
            open_bank_s = ~wr_bank_q;
          end else begin
            open_req_s = 1'b0;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Opening sees this cycle's commit and release already applied.
    if (open_req_s) begin
      if (!committed_d[open_bank_s]) begin
        state_d  = ST_CAPTURE;
        wr_ptr_d = {ADDRESS_WIDTH{1'b0}};
        len_d    = {(ADDRESS_WIDTH+1){1'b0}};
        ovf_d    = 1'b0;
      end else begin
        state_d = ST_DISCARD;
        drop_d  = sat_inc(drop_q);
      end
    end else begin
      drop_d = drop_q;
    end

    frame_ready_d = committed_d[rd_bank_d];
    if (committed_d[rd_bank_d]) begin
      frame_len_d = bank_len_d[rd_bank_d];
      frame_ovf_d = bank_ovf_d[rd_bank_d];
    end else begin
      frame_len_d = {(ADDRESS_WIDTH+1){1'b0}};
      frame_ovf_d = 1'b0;
    end
  end

  // State registers with async reset and synchronous flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      committed_q   <= {NUM_BANKS{1'b0}};
      wr_ptr_q      <= {ADDRESS_WIDTH{1'b0}};
      len_q         <= {(ADDRESS_WIDTH+1){1'b0}};
      ovf_q         <= 1'b0;
      bank_len_q    <= '0;
      bank_ovf_q    <= {NUM_BANKS{1'b0}};
      drop_q        <= {DROP_W{1'b0}};
      frame_ready_q <= 1'b0;
      frame_len_q   <= {(ADDRESS_WIDTH+1){1'b0}};
      frame_ovf_q   <= 1'b0;
    end else if (clear) begin
      state_q       <= ST_IDLE;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      committed_q   <= {NUM_BANKS{1'b0}};
      wr_ptr_q      <= {ADDRESS_WIDTH{1'b0}};
      len_q         <= {(ADDRESS_WIDTH+1){1'b0}};
      ovf_q         <= 1'b0;
      bank_len_q    <= '0;
      bank_ovf_q    <= {NUM_BANKS{1'b0}};
      drop_q        <= {DROP_W{1'b0}};
      frame_ready_q <= 1'b0;
      frame_len_q   <= {(ADDRESS_WIDTH+1){1'b0}};
      frame_ovf_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      committed_q   <= committed_d;
      wr_ptr_q      <= wr_ptr_d;
      len_q         <= len_d;
      ovf_q         <= ovf_d;
      bank_len_q    <= bank_len_d;
      bank_ovf_q    <= bank_ovf_d;
      drop_q        <= drop_d;
      frame_ready_q <= frame_ready_d;
      frame_len_q   <= frame_len_d;
      frame_ovf_q   <= frame_ovf_d;
    end
  end

  frame_capture_pingpong_buffer_dpram #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH + 1)
  ) u_dpram (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_enable(we_s),
    .write_addr  (waddr_s),
    .write_data  (data_in),
    .read_addr   ({rd_bank_q, addr}),
    .read_data   (data)
  );

  assign frame_ready = frame_ready_q;
  assign frame_len   = frame_len_q;
  assign frame_ovf   = frame_ovf_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_frame_capture_pingpong_buffer.sv
// Directed bench: stop-mode and wrap-mode instances share stimulus; expected
// values go through a scoreboard queue and are checked with immediate assertions.
module tb_frame_capture_pingpong_buffer;

  logic       clk = 1'b0;
  logic       rst_n, clear, frame_start, frame_end, data_in_valid, frame_release;
  logic [7:0] data_in;
  logic [5:0] addr;
  logic       frame_ready_0, frame_ovf_0, frame_ready_1, frame_ovf_1;
  logic [6:0] frame_len_0, frame_len_1;
  logic [7:0] data_0, data_1, drop_count_0, drop_count_1;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  frame_capture_pingpong_buffer #(.DATA_WIDTH(8), .ADDRESS_WIDTH(6), .WRAP_MODE(0)) u_stop (
    .clk(clk), .rst_n(rst_n), .clear(clear), .frame_start(frame_start), .frame_end(frame_end),
    .data_in(data_in), .data_in_valid(data_in_valid), .frame_ready(frame_ready_0),
    .frame_len(frame_len_0), .frame_ovf(frame_ovf_0), .frame_release(frame_release),
    .addr(addr), .data(data_0), .drop_count(drop_count_0));

  frame_capture_pingpong_buffer #(.DATA_WIDTH(8), .ADDRESS_WIDTH(6), .WRAP_MODE(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .frame_start(frame_start), .frame_end(frame_end),
    .data_in(data_in), .data_in_valid(data_in_valid), .frame_ready(frame_ready_1),
    .frame_len(frame_len_1), .frame_ovf(frame_ovf_1), .frame_release(frame_release),
    .addr(addr), .data(data_1), .drop_count(drop_count_1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: scoreboard empty, observed=%0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic status0(input string tag, input logic rdy, input int len, input logic ovf);
    push_exp({31'd0, rdy});
    push_exp(32'(len));
    push_exp({31'd0, ovf});
    check({tag, ".ready"}, {31'd0, frame_ready_0});
    check({tag, ".len"}, {25'd0, frame_len_0});
    check({tag, ".ovf"}, {31'd0, frame_ovf_0});
  endtask

  task automatic status1(input string tag, input logic rdy, input int len, input logic ovf);
    push_exp({31'd0, rdy});
    push_exp(32'(len));
    push_exp({31'd0, ovf});
    check({tag, ".ready"}, {31'd0, frame_ready_1});
    check({tag, ".len"}, {25'd0, frame_len_1});
    check({tag, ".ovf"}, {31'd0, frame_ovf_1});
  endtask

  task automatic drop0(input string tag, input int v);
    push_exp(32'(v));
    check(tag, {24'd0, drop_count_0});
  endtask

  task automatic send(input logic [7:0] v);
    data_in       = v;
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic pulse_release();
    frame_release = 1'b1;
    step();
    frame_release = 1'b0;
  endtask

  task automatic rd0(input logic [5:0] a, input logic [7:0] e);
    push_exp({24'd0, e});
    addr = a;
    step();
    check("rd_stop", {24'd0, data_0});
  endtask

  task automatic rd1(input logic [5:0] a, input logic [7:0] e);
    push_exp({24'd0, e});
    addr = a;
    step();
    check("rd_wrap", {24'd0, data_1});
  endtask

  task automatic frame_of(input logic [7:0] base, input int n);
    pulse_start();
    for (int i = 0; i < n; i++) send(base + 8'(i));
    pulse_end();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    data_in = 8'h00; data_in_valid = 1'b0; frame_release = 1'b0; addr = 6'd0;
    step(); step();
    status0("reset", 1'b0, 0, 1'b0);
    drop0("reset.drop", 0);
    rst_n = 1'b1;
    step();

    // Basic five-sample frame.
    frame_of(8'h11, 5);
    status0("basic", 1'b1, 5, 1'b0);
    for (int i = 0; i < 5; i++) rd0(6'(i), 8'h11 + 8'(i));
    pulse_release();
    status0("basic_rel", 1'b0, 0, 1'b0);

    // 70 samples into a 64-word bank.
    frame_of(8'h00, 70);
    status0("ovf_stop", 1'b1, 64, 1'b1);
    status1("ovf_wrap", 1'b1, 64, 1'b1);
    rd0(6'd63, 8'd63);
    for (int i = 0; i < 6; i++) rd1(6'(i), 8'(64 + i));
    rd1(6'd6, 8'd6);
    pulse_release();
    status0("ovf_rel", 1'b0, 0, 1'b0);

    // Three frames without release: the third has no bank.
    frame_of(8'h30, 3);
    frame_of(8'h40, 4);
    frame_of(8'h50, 2);
    status0("three", 1'b1, 3, 1'b0);
    drop0("three.drop", 1);
    push_exp(32'd1);
    check("three.drop_wrap", {24'd0, drop_count_1});
    rd0(6'd0, 8'h30);
    pulse_release();
    status0("three_rel1", 1'b1, 4, 1'b0);
    rd0(6'd3, 8'h43);
    pulse_release();
    status0("three_rel2", 1'b0, 0, 1'b0);

    // Abort and restart on the same bank.
    pulse_start();
    send(8'h01); send(8'h02); send(8'h03);
    pulse_start();
    send(8'hA0); send(8'hA1);
    pulse_end();
    status0("abort", 1'b1, 2, 1'b0);
    rd0(6'd0, 8'hA0);
    rd0(6'd1, 8'hA1);
    pulse_release();

    // Start+end with a sample in the same cycle: sample closes frame, next opens.
    pulse_start();
    send(8'h61); send(8'h62);
    frame_start = 1'b1; frame_end = 1'b1; data_in = 8'h63; data_in_valid = 1'b1;
    step();
    frame_start = 1'b0; frame_end = 1'b0; data_in_valid = 1'b0;
    send(8'h71);
    pulse_end();
    status0("se", 1'b1, 3, 1'b0);
    rd0(6'd2, 8'h63);
    pulse_release();
    status0("se_rel", 1'b1, 1, 1'b0);
    rd0(6'd0, 8'h71);
    pulse_release();
    pulse_end();
    status0("idle_end", 1'b0, 0, 1'b0);
    drop0("idle_end.drop", 1);

    // Asynchronous reset in the middle of a capture.
    pulse_start();
    send(8'h01); send(8'h02);
    rst_n = 1'b0;
    #1;
    status0("async_rst", 1'b0, 0, 1'b0);
    drop0("async_rst.drop", 0);
    step();
    rst_n = 1'b1;
    step();

    // Synchronous clear with banks pending and a drop recorded.
    frame_of(8'h77, 1);
    frame_of(8'h78, 1);
    frame_of(8'h79, 1);
    status0("pre_clear", 1'b1, 1, 1'b0);
    drop0("pre_clear.drop", 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    status0("clear", 1'b0, 0, 1'b0);
    drop0("clear.drop", 0);
    frame_of(8'h99, 1);
    status0("post_clear", 1'b1, 1, 1'b0);
    rd0(6'd0, 8'h99);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
